bcd_display_mux: RTL and testbench
==================================

BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clocks each digit is driven per scan slot; legal range 2 to 2^20.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 ones  input  4  BCD units digit from the upstream multi-decade counter.
REQ-005 tens  input  4  BCD tens digit.
REQ-006 hundreds  input  4  BCD hundreds digit.
REQ-007 load  input  1  snapshot strobe; digits are captured on any edge where load=1.
REQ-008 done_in  input  1  counter-wrap pulse from upstream; sets the overflow flag.
REQ-009 clear_ovf  input  1  clears the overflow flag.
REQ-010 blank_lz  input  1  leading-zero blanking enable.
REQ-011 an  output  3  digit anodes, active-low, one-hot: bit0 ones, bit1 tens, bit2 hundreds.
REQ-012 seg  output  7  segment cathodes, active-low, bit order {g,f,e,d,c,b,a}.
REQ-013 dp  output  1  decimal point, active-low.
REQ-014 ovf  output  1  sticky overflow flag, active-high.

Function
REQ-015 Prescaler counts 0..REFRESH_DIV-1 and wraps to 0; its terminal count advances the digit index.
REQ-016 Digit index states DIG0 -> DIG1 -> DIG2 -> DIG0; it changes only on prescaler terminal count.
REQ-017 Snapshot registers capture ones/tens/hundreds when load=1; otherwise they hold; display uses only snapshot values.
REQ-018 an/seg/dp are registered, reflecting the digit index and snapshot one clock after either changes.
REQ-019 an is 3'b110 in DIG0, 3'b101 in DIG1, 3'b011 in DIG2; never more than one bit low.
REQ-020 Decode 0-9 to seg hex: 40,79,24,30,19,12,02,78,00,10.
REQ-021 Illegal BCD codes 10-15 decode to dash 7'h3F (segment g only).
REQ-022 With blank_lz=1: hundreds blanked when snapshot hundreds=0; tens blanked when hundreds=0 and tens=0; ones never blanked.
REQ-023 Blanked digit keeps its anode asserted and drives seg=7'h7F.
REQ-024 ovf sets on the edge after done_in=1, clears on the edge after clear_ovf=1; simultaneous done_in and clear_ovf leaves ovf=1.
REQ-025 dp=0 only in DIG2 while ovf=1; otherwise dp=1.
REQ-026 load and done_in in the same cycle are both honoured; the snapshot and ovf updates are independent.
REQ-027 blank_lz changes take effect on the next registered output update with no scan restart.

Reset
REQ-028 rst=1 on an edge forces prescaler=0, index=DIG0, snapshots=0, ovf=0, an=3'b111, seg=7'h7F, dp=1.
REQ-029 rst has priority over load, done_in and clear_ovf in the same cycle.
REQ-030 Assertion mid-scan aborts the slot; the first edge after release drives an=3'b110 with the ones snapshot (0 -> seg=7'h40).

Verification
REQ-031 REFRESH_DIV=4, load=1 with 1/2/3 -> an cycles 110,101,011 every 4 clocks; seg 79,24,30 respectively.
REQ-032 blank_lz=1, digits 0/0/7 -> hundreds and tens slots seg=7'h7F, ones slot seg=7'h78; blank_lz=0 -> 40,40,78.
REQ-033 load pulse with 4/5/6 then load=0 while inputs change to 9/9/9 -> display still shows 4,5,6.
REQ-034 done_in pulse -> ovf=1, dp=0 in DIG2 slot only; done_in and clear_ovf together -> ovf stays 1; clear_ovf alone -> ovf=0, dp=1.
REQ-035 ones=4'hC loaded -> ones slot seg=7'h3F.
REQ-036 rst asserted in DIG1 slot -> next edge an=3'b111, seg=7'h7F, ovf=0; after release an=3'b110 for exactly 4 clocks.

Source files
------------

// File: rtl/bcd_display_mux.sv
// Time-multiplexed driver for a three-digit common-anode 7-segment display.
// Digits come from load-captured snapshots and can have leading zeros blanked; dp lights on the hundreds digit while overflow is latched.
module bcd_display_mux #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic       load,
    input  logic       done_in,
    input  logic       clear_ovf,
    input  logic       blank_lz,
    output logic [2:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       ovf
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2
    } dig_t;

    logic [CNT_W-1:0] r_presc;
    dig_t             r_idx;
    dig_t             w_idx_nxt;
    logic             w_tc;
    logic [3:0]       r_ones;
    logic [3:0]       r_tens;
    logic [3:0]       r_hund;
    logic             r_ovf;
    logic [2:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic [2:0]       w_an;
    logic [3:0]       w_digit;
    logic             w_blank;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    assign w_tc = (r_presc == CNT_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tc) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= DIG0;
        end else begin
            r_idx <= w_idx_nxt;
        end
    end

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_tc) begin
            case (r_idx)
                DIG0:    w_idx_nxt = DIG1;
                DIG1:    w_idx_nxt = DIG2;
                default: w_idx_nxt = DIG0;
            endcase
        end
    end

    // Snapshot and overflow paths are independent so load and done_in can coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ones <= '0;
            r_tens <= '0;
            r_hund <= '0;
        end else if (load) begin
            r_ones <= ones;
            r_tens <= tens;
            r_hund <= hundreds;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (done_in) begin
            r_ovf <= 1'b1;
        end else if (clear_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    always_comb begin
        w_an    = 3'b110;
        w_digit = r_ones;
        w_blank = 1'b0;
        case (r_idx)
            DIG1: begin
                w_an    = 3'b101;
                w_digit = r_tens;
                w_blank = blank_lz && (r_hund == 4'd0) && (r_tens == 4'd0);
            end
            DIG2: begin
                w_an    = 3'b011;
                w_digit = r_hund;
                w_blank = blank_lz && (r_hund == 4'd0);
            end
            default: begin
                w_an    = 3'b110;
                w_digit = r_ones;
                w_blank = 1'b0;
            end
        endcase
    end

    // Output register stage: display lags index/snapshot by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= 3'b111;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an;
            r_seg <= w_blank ? 7'h7F : bcd_to_seg(w_digit);
            r_dp  <= !((r_idx == DIG2) && r_ovf);
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux with a 4-clock scan slot.
module tb_bcd_display_mux;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic       load;
    logic       done_in;
    logic       clear_ovf;
    logic       blank_lz;
    logic [2:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ovf;

    int tests = 0;
    int fails = 0;

    bcd_display_mux #(.REFRESH_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .load      (load),
        .done_in   (done_in),
        .clear_ovf (clear_ovf),
        .blank_lz  (blank_lz),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full 12-clock scan starting at a DIG0 slot boundary; control inputs apply to the first edge only.
    task automatic frame(input string tag, input logic ld, input logic [3:0] o, input logic [3:0] t,
                         input logic [3:0] h, input logic dn, input logic cl, input logic bl,
                         input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                         input logic dp2, input logic ov);
        logic [2:0] exp_an;
        load = ld; ones = o; tens = t; hundreds = h;
        done_in = dn; clear_ovf = cl; blank_lz = bl;
        for (int e = 0; e < 12; e++) begin
            step();
            if (e == 0) begin
                load = 1'b0; done_in = 1'b0; clear_ovf = 1'b0;
                ones = 4'd9; tens = 4'd9; hundreds = 4'd9;
                check({tag, ".ovf"}, {7'd0, ovf}, {7'd0, ov});
            end
            exp_an = (e < 4) ? 3'b110 : (e < 8) ? 3'b101 : 3'b011;
            check({tag, ".an"}, {5'd0, an}, {5'd0, exp_an});
            if (e == 3) check({tag, ".seg0"}, {1'b0, seg}, {1'b0, s0});
            if (e == 7) check({tag, ".seg1"}, {1'b0, seg}, {1'b0, s1});
            if (e == 11) check({tag, ".seg2"}, {1'b0, seg}, {1'b0, s2});
            if (e == 7) check({tag, ".dp1"}, {7'd0, dp}, 8'd1);
            if (e == 11) check({tag, ".dp2"}, {7'd0, dp}, {7'd0, dp2});
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; done_in = 1'b0; clear_ovf = 1'b0; blank_lz = 1'b0;
        ones = 4'd0; tens = 4'd0; hundreds = 4'd0;
        step();
        step();
        check("rst.an", {5'd0, an}, 8'h07);
        check("rst.seg", {1'b0, seg}, 8'h7F);
        check("rst.dp", {7'd0, dp}, 8'd1);
        check("rst.ovf", {7'd0, ovf}, 8'd0);
        rst = 1'b0;

        frame("scan123", 1'b1, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0, 7'h79, 7'h24, 7'h30, 1'b1, 1'b0);
        frame("blank007", 1'b1, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 7'h78, 7'h7F, 7'h7F, 1'b1, 1'b0);
        frame("noblank007", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 7'h78, 7'h40, 7'h40, 1'b1, 1'b0);
        frame("hold456", 1'b1, 4'd4, 4'd5, 4'd6, 1'b0, 1'b0, 1'b0, 7'h19, 7'h12, 7'h02, 1'b1, 1'b0);
        frame("illegalC", 1'b1, 4'hC, 4'd0, 4'd8, 1'b1, 1'b0, 1'b1, 7'h3F, 7'h40, 7'h00, 1'b0, 1'b1);
        frame("doneclr", 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 7'h3F, 7'h40, 7'h00, 1'b0, 1'b1);

        for (int e = 0; e < 5; e++) step();
        check("mid.an", {5'd0, an}, 8'h05);
        rst = 1'b1; load = 1'b1; done_in = 1'b1;
        ones = 4'd5; tens = 4'd5; hundreds = 4'd5;
        step();
        check("midrst.an", {5'd0, an}, 8'h07);
        check("midrst.seg", {1'b0, seg}, 8'h7F);
        check("midrst.dp", {7'd0, dp}, 8'd1);
        check("midrst.ovf", {7'd0, ovf}, 8'd0);
        rst = 1'b0; load = 1'b0; done_in = 1'b0;

        frame("postrst", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 7'h40, 7'h40, 7'h40, 1'b1, 1'b0);
        frame("ovfset", 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 7'h40, 7'h40, 7'h40, 1'b0, 1'b1);
        frame("ovfclr", 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 7'h40, 7'h40, 7'h40, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
